// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler: the 3-bit FSM state
// encoding, the default FIFO depth and a small state classification helper.
// Kept as plain localparam constants so the encoding stays fixed for older
// blocks that compare state values directly.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DEPTH_DEFAULT = 64;
    localparam int STATE_W            = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_LATCH = 3'd2;
    localparam logic [STATE_W-1:0] ST_SEND  = 3'd3;
    localparam logic [STATE_W-1:0] ST_HOLD  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd5;

    // True while a word has been pulled from the FIFO (or is about to be)
    // and must be carried through to the transmitter before anything else.
    function automatic logic in_flight(input logic [STATE_W-1:0] s);
        return (s == ST_FETCH) || (s == ST_LATCH) ||
               (s == ST_SEND)  || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Scheduler sitting between a host write port, an external FIFO and a UART
// transmitter. It guards the FIFO against overflow, tracks its occupancy,
// pulls one word per frame and hands it to the transmitter with a single
// tx_start pulse. A flush request discards everything queued.
//
// Ports
//   CLK, RST          single rising-edge clock, synchronous active-high reset
//   wr_valid/wr_data  host word offered; wr_ready says it can be taken
//   fifo_w_enable/    FIFO write strobe and data (combinational from host)
//   fifo_w_data
//   fifo_r_enable     FIFO read strobe; fifo_r_data is valid one cycle later
//   fifo_r_data
//   tx_busy           transmitter is shifting a frame
//   tx_start/tx_data  one-cycle start pulse and the word to transmit
//   tx_en             permits starting new fetches
//   flush             discard all queued words
//   occ/empty/full    FIFO occupancy and its flags
//   idle              FSM idle with nothing queued
//
// The FIFO itself lives in the parent and must share RST with this block so
// that its pointers and occ are cleared together.
// ---------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = UART_DEPTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  fifo_w_enable,
    output logic [DATA_WIDTH-1:0] fifo_w_data,
    output logic                  fifo_r_enable,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_en,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   occ,
    output logic                  empty,
    output logic                  full,
    output logic                  idle
);

    typedef logic [ADDR_WIDTH:0] occ_t;

    localparam occ_t DEPTH_C = occ_t'(DEPTH);
    localparam occ_t ONE_C   = occ_t'(1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    occ_t               occ_r;
    logic               occ_zero;
    logic               flushing;
    logic               accept;
    logic               rd_en;
    logic               start;
    logic               flush_pend;

    assign occ_zero = (occ_r == '0);
    assign flushing = (state == ST_DRAIN);

    // Host side: a write is only taken when the FIFO has room and no drain is
    // running. Reset forces the handshake closed so nothing lands in a FIFO
    // whose pointers are being cleared on the same edge.
    assign full          = (occ_r == DEPTH_C);
    assign empty         = occ_zero;
    assign wr_ready      = !RST && !full && !flushing;
    assign accept        = wr_valid && wr_ready;
    assign fifo_w_enable = accept;
    assign fifo_w_data   = wr_data;

    assign occ  = occ_r;
    assign idle = (state == ST_IDLE) && occ_zero;

    assign fifo_r_enable = rd_en;
    assign tx_start      = start;

    // Next-state and strobe decode. Reads are additionally gated by occ so a
    // read can never be issued against an empty FIFO.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!occ_zero) begin
                    if (flush || flush_pend) begin
                        state_nxt = ST_DRAIN;
                    end else if (tx_en) begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                rd_en     = !occ_zero;
                state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                start = !tx_busy;
                if (!tx_busy) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Gives the transmitter one edge to raise tx_busy before the
                // next fetch can reach SEND.
                state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                rd_en = !occ_zero;
                // Writes are blocked here, so occ only falls; leave as the
                // last entry is read out.
                if (occ_r <= ONE_C) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (RST) begin
            state_nxt = ST_IDLE;
            rd_en     = 1'b0;
            start     = 1'b0;
        end
    end

    // State, occupancy and output data registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            occ_r      <= '0;
            tx_data    <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_nxt;

            // Accept and read on the same edge cancel out.
            case ({accept, rd_en})
                2'b10:   occ_r <= occ_r + ONE_C;
                2'b01:   occ_r <= occ_r - ONE_C;
                default: occ_r <= occ_r;
            endcase

            // fifo_r_data answers the FETCH read during LATCH.
            if (state == ST_LATCH) begin
                tx_data <= fifo_r_data;
            end

            // A flush seen while a word is in flight is remembered until the
            // FSM is back in IDLE, where it is acted on.
            if (in_flight(state)) begin
                if (flush) begin
                    flush_pend <= 1'b1;
                end
            end else begin
                flush_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched with a behavioural FIFO and a
// transmitter model that stays busy for busy_len cycles after each start.
// Words expected on the transmitter are queued when written and checked in
// order on each tx_start.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int DEP = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          fifo_w_enable;
    logic [DW-1:0] fifo_w_data;
    logic          fifo_r_enable;
    logic [DW-1:0] fifo_r_data;
    logic          tx_busy;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_en;
    logic          flush;
    logic [AW:0]   occ;
    logic          empty;
    logic          full;
    logic          idle;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int n_reads  = 0;
    int n_starts = 0;

    logic [DW-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    uart_tx_sched #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEP)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .fifo_w_enable(fifo_w_enable),
        .fifo_w_data  (fifo_w_data),
        .fifo_r_enable(fifo_r_enable),
        .fifo_r_data  (fifo_r_data),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_en        (tx_en),
        .flush        (flush),
        .occ          (occ),
        .empty        (empty),
        .full         (full),
        .idle         (idle)
    );

    // Behavioural FIFO sharing RST with the scheduler; read data one cycle
    // after the strobe.
    logic [DW-1:0] mem [DEP];
    int            wp;
    int            rp;

    always @(posedge CLK) begin
        if (RST) begin
            wp          <= 0;
            rp          <= 0;
            fifo_r_data <= '0;
        end else begin
            if (fifo_w_enable) begin
                mem[wp] <= fifo_w_data;
                wp      <= (wp + 1) % DEP;
            end
            if (fifo_r_enable) begin
                fifo_r_data <= mem[rp];
                rp          <= (rp + 1) % DEP;
            end
        end
    end

    // Transmitter model: busy from the edge after tx_start for busy_len
    // cycles; hold_busy pins it busy for the reset scenario.
    int   busy_len  = 0;
    int   busy_cnt  = 0;
    logic hold_busy = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            busy_cnt <= 0;
        end else if (tx_start) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign tx_busy = (busy_cnt > 0) || hold_busy;

    function automatic void check_output(input string name,
                                         input logic [31:0] act,
                                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    // Scoreboard side: every start must have a queued word, in order, and
    // no read may be issued against an empty FIFO.
    always @(negedge CLK) begin
        logic [DW-1:0] exp_d;
        if (!RST) begin
            if (fifo_r_enable) begin
                n_reads++;
                check_output("r_enable_nonempty", 32'(occ != 0), 1);
            end
            if (tx_start) begin
                n_starts++;
                check_output("tx_start_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_d = exp_q.pop_front();
                    check_output("tx_data", 32'(tx_data), 32'(exp_d));
                end
            end
        end
    end

    // Called just after a rising edge: offers one word for one edge and
    // checks the handshake against the expected acceptance.
    task automatic apply_stimulus(input logic [DW-1:0] d, input bit exp_acc);
        wr_valid = 1'b1;
        wr_data  = d;
        #1;
        check_output("wr_ready", 32'(wr_ready), 32'(exp_acc));
        check_output("fifo_w_enable", 32'(fifo_w_enable), 32'(exp_acc));
        if (exp_acc) begin
            check_output("fifo_w_data", 32'(fifo_w_data), 32'(d));
            exp_q.push_back(d);
        end
        @(posedge CLK);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge CLK);
            #1;
            if (idle && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_output("wait_idle", 32'(ok), 1);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        int            busy_len;
        int            exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int lat;
        int st[3];
        int s0;
        int r0;

        vecs[0] = '{8'hA5, 0, 3};
        vecs[1] = '{8'h00, 0, 3};
        vecs[2] = '{8'hFF, 4, 3};
        vecs[3] = '{8'h5A, 1, 3};
        vecs[4] = '{8'h3C, 2, 3};

        RST      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        tx_en    = 1'b0;
        flush    = 1'b0;

        // Reset: handshake and strobes held low even with a word offered.
        @(posedge CLK);
        #1;
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        tx_en    = 1'b1;
        #1;
        check_output("rst_wr_ready", 32'(wr_ready), 0);
        check_output("rst_fifo_w_enable", 32'(fifo_w_enable), 0);
        check_output("rst_fifo_r_enable", 32'(fifo_r_enable), 0);
        check_output("rst_tx_start", 32'(tx_start), 0);
        @(posedge CLK);
        #1;
        check_output("rst_occ", 32'(occ), 0);
        check_output("rst_empty", 32'(empty), 1);
        check_output("rst_full", 32'(full), 0);
        check_output("rst_idle", 32'(idle), 1);
        check_output("rst_tx_data", 32'(tx_data), 0);
        wr_valid = 1'b0;
        tx_en    = 1'b0;
        RST      = 1'b0;
        @(posedge CLK);
        #1;

        // Single words into an empty queue: start three edges after accept.
        tx_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            busy_len = vecs[i].busy_len;
            apply_stimulus(vecs[i].data, 1'b1);
            acc = cyc;
            check_output("occ_after_accept", 32'(occ), 1);
            lat = -1;
            for (int k = 0; k < 20; k++) begin
                @(posedge CLK);
                #1;
                if (tx_start) begin
                    lat = cyc - acc;
                    break;
                end
            end
            check_output("latency", 32'(lat), 32'(vecs[i].exp_lat));
            wait_idle(40);
            check_output("occ_drained", 32'(occ), 0);
        end

        // Ordering with a slow transmitter.
        tx_en    = 1'b0;
        busy_len = 10;
        apply_stimulus(8'h01, 1'b1);
        apply_stimulus(8'h02, 1'b1);
        apply_stimulus(8'h03, 1'b1);
        tx_en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            st[f] = -1;
            for (int k = 0; k < 40; k++) begin
                @(posedge CLK);
                #1;
                if (tx_start) begin
                    st[f] = cyc;
                    break;
                end
            end
            check_output("order_start_seen", 32'(st[f] != -1), 1);
        end
        check_output("order_gap_1", 32'((st[1] - st[0]) >= 11), 1);
        check_output("order_gap_2", 32'((st[2] - st[1]) >= 11), 1);
        wait_idle(60);

        // Fill to DEPTH with the transmitter disabled; two extra words refused.
        tx_en    = 1'b0;
        busy_len = 2;
        for (int i = 0; i < DEP + 2; i++) begin
            apply_stimulus(8'(8'h40 + i), i < DEP);
        end
        check_output("fill_full", 32'(full), 1);
        check_output("fill_occ", 32'(occ), DEP);
        check_output("fill_wr_ready", 32'(wr_ready), 0);
        check_output("fill_empty", 32'(empty), 0);
        s0    = n_starts;
        tx_en = 1'b1;
        wait_idle(DEP * 12 + 20);
        check_output("fill_starts", 32'(n_starts - s0), DEP);
        check_output("fill_queue_empty", 32'(exp_q.size()), 0);

        // Write landing on the FETCH read edge leaves occ unchanged.
        tx_en    = 1'b0;
        busy_len = 0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(8'(8'h60 + i), 1'b1);
        end
        check_output("simul_occ_before", 32'(occ), 5);
        tx_en = 1'b1;
        @(posedge CLK);
        #1;
        check_output("simul_fetch_read", 32'(fifo_r_enable), 1);
        apply_stimulus(8'h77, 1'b1);
        check_output("simul_occ_after", 32'(occ), 5);
        wait_idle(100);
        check_output("simul_drained", 32'(occ), 0);

        // Flush from idle with four words; flush wins over tx_en.
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(8'(8'h80 + i), 1'b1);
        end
        check_output("flush_occ_before", 32'(occ), 4);
        check_output("flush_idle_before", 32'(idle), 0);
        r0    = n_reads;
        s0    = n_starts;
        tx_en = 1'b1;
        flush = 1'b1;
        @(posedge CLK);
        #1;
        flush = 1'b0;
        exp_q.delete();
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_output("drain_r_enable", 32'(fifo_r_enable), 1);
            check_output("drain_wr_ready", 32'(wr_ready), 0);
            check_output("drain_w_enable", 32'(fifo_w_enable), 0);
            @(posedge CLK);
            #1;
        end
        wr_valid = 1'b0;
        #1;
        check_output("flush_r_enable_end", 32'(fifo_r_enable), 0);
        check_output("flush_idle", 32'(idle), 1);
        check_output("flush_occ", 32'(occ), 0);
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        check_output("flush_reads", 32'(n_reads - r0), 4);
        check_output("flush_no_start", 32'(n_starts - s0), 0);

        // Reset while waiting in SEND with three words still queued.
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(8'(8'hC0 + i), 1'b1);
        end
        hold_busy = 1'b1;
        tx_en     = 1'b1;
        repeat (6) begin
            @(posedge CLK);
            #1;
        end
        check_output("send_wait_occ", 32'(occ), 3);
        check_output("send_wait_start", 32'(tx_start), 0);
        RST       = 1'b1;
        hold_busy = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'h55;
        #1;
        check_output("rst_send_tx_start", 32'(tx_start), 0);
        check_output("rst_send_wr_ready", 32'(wr_ready), 0);
        check_output("rst_send_r_enable", 32'(fifo_r_enable), 0);
        check_output("rst_send_w_enable", 32'(fifo_w_enable), 0);
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        r0 = n_reads;
        s0 = n_starts;
        #1;
        check_output("post_rst_occ", 32'(occ), 0);
        check_output("post_rst_idle", 32'(idle), 1);
        check_output("post_rst_tx_start", 32'(tx_start), 0);
        check_output("post_rst_tx_data", 32'(tx_data), 0);
        repeat (6) begin
            @(posedge CLK);
            #1;
        end
        check_output("post_rst_reads", 32'(n_reads - r0), 0);
        check_output("post_rst_starts", 32'(n_starts - s0), 0);
        check_output("post_rst_still_idle", 32'(idle), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: width of the occupancy counter, which is ADDR_WIDTH+1 bits.
REQ-003 SHALL have parameter DEPTH, default 64: number of usable FIFO entries; legal range is 2 to 2**ADDR_WIDTH.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port wr_valid, input, 1 bit: host presents a word.
REQ-007 SHALL have port wr_data, input, DATA_WIDTH bits: host word.
REQ-008 SHALL have port wr_ready, output, 1 bit: the controller can accept a word.
REQ-009 SHALL have port fifo_w_enable, output, 1 bit: FIFO write strobe.
REQ-010 SHALL have port fifo_w_data, output, DATA_WIDTH bits: FIFO write data.
REQ-011 SHALL have port fifo_r_enable, output, 1 bit: FIFO read strobe.
REQ-012 SHALL have port fifo_r_data, input, DATA_WIDTH bits: FIFO read data, valid one cycle after fifo_r_enable.
REQ-013 SHALL have port tx_busy, input, 1 bit: the transmitter is shifting a frame.
REQ-014 SHALL have port tx_start, output, 1 bit: single-cycle frame start pulse.
REQ-015 SHALL have port tx_data, output, DATA_WIDTH bits: word to transmit.
REQ-016 SHALL have port tx_en, input, 1 bit: permits draining to the transmitter.
REQ-017 SHALL have port flush, input, 1 bit: discard all queued words.
REQ-018 SHALL have port occ, output, ADDR_WIDTH+1 bits: entries held in the FIFO.
REQ-019 SHALL have port empty, output, 1 bit: asserted when occ==0.
REQ-020 SHALL have port full, output, 1 bit: asserted when occ==DEPTH.
REQ-021 SHALL have port idle, output, 1 bit: FSM in IDLE and occ==0.

Function
REQ-022 SHALL guard the FIFO against overflow: wr_ready = !full && !flushing, and a write is accepted only when wr_valid && wr_ready.
REQ-023 SHALL, on an accepted write, drive fifo_w_enable=1 and fifo_w_data=wr_data in the same cycle, combinationally.
REQ-024 SHALL update occ each edge as occ + accept - fifo_r_enable; a simultaneous accept and read leaves occ unchanged, and occ never wraps.
REQ-025 SHALL implement FSM states IDLE, FETCH, LATCH, SEND, HOLD, DRAIN.
REQ-026 SHALL move from IDLE to DRAIN when flush=1 and occ>0; flush has priority over transmit.
REQ-027 SHALL move from IDLE to FETCH when tx_en=1, occ>0 and flush=0; otherwise IDLE holds.
REQ-028 SHALL assert fifo_r_enable=1 for exactly one cycle in FETCH and go to LATCH.
REQ-029 SHALL, in LATCH, register tx_data from fifo_r_data and go to SEND.
REQ-030 SHALL, in SEND, drive tx_start = !tx_busy and go to HOLD when tx_start=1; while tx_busy=1 it waits in SEND.
REQ-031 SHALL spend exactly one cycle in HOLD, ignoring tx_busy, and then go to IDLE.
REQ-032 SHALL, in DRAIN, assert fifo_r_enable every cycle while occ>0, discard the data, and return to IDLE when occ reaches 0; writes are blocked throughout (flushing=1).
REQ-033 SHALL let flush asserted in FETCH through HOLD complete the word in flight first, then enter DRAIN from IDLE.
REQ-034 SHALL let tx_en deassertion stop only new fetches; a word already in flight still completes.
REQ-035 SHALL give a latency, for an empty FIFO with an idle transmitter, from the accept edge to tx_start=1 of the third cycle after it: IDLE, FETCH, LATCH, then SEND.
REQ-036 SHALL never assert fifo_r_enable when occ==0, and never assert fifo_r_enable twice for one frame.
REQ-037 SHALL sustain at best one word per frame; the transmitter must raise tx_busy on the edge after tx_start.

Reset
REQ-038 SHALL, while RST=1 at an edge, set state=IDLE, occ=0 and tx_data=0, drive fifo_w_enable=0, fifo_r_enable=0 and tx_start=0, and force wr_ready=0.
REQ-039 SHALL, after a reset mid-operation, discard any in-flight word; the FIFO pointers must be reset together with this block, on the same RST.

Structure
REQ-040 SHALL keep the FSM state encoding (3 bits) and the DEPTH default in the shared package uart_pkg.
REQ-041 SHALL be a single module with no sub-modules; the occupancy counter and FSM are inline, and the FIFO is instantiated alongside by the parent.

Verification
REQ-042 SHALL cover single word: write 0xA5 into an empty queue with tx_busy=0 -> tx_start pulse 3 cycles after the accept, tx_data=0xA5, occ back to 0.
REQ-043 SHALL cover fill: with tx_en=0, write DEPTH+2 words -> wr_ready=0 after DEPTH accepts, full=1, occ=DEPTH, the extra 2 words are not accepted.
REQ-044 SHALL cover ordering: queue 0x01, 0x02, 0x03 with a transmitter model that is busy for 10 cycles per frame -> three tx_start pulses, each at least 11 cycles apart, data in order 0x01, 0x02, 0x03.
REQ-045 SHALL cover simultaneous events: write during FETCH at occ=5 -> occ stays 5 on that edge.
REQ-046 SHALL cover flush: flush=1 with occ=4 and FSM idle -> 4 consecutive fifo_r_enable cycles, no tx_start, wr_ready=0 throughout, then idle=1.
REQ-047 SHALL cover reset: RST=1 while in SEND with occ=3 -> next cycle occ=0, state IDLE, tx_start=0, and no further fifo_r_enable.
